// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq: Avalon-MM input PIO for pushbuttons/switches.
// Each bit passes a 2-flop synchroniser and a debounce filter, then feeds an
// edge detector into a sticky, write-1-to-clear capture register with a
// maskable level interrupt.
// Build option: define PIO_IN_DEBOUNCE_EN to build the per-bit debounce
// counters; without it the debounced state simply follows the synchroniser.
module pio_in_edge_irq #(
  parameter int unsigned      WIDTH           = 4,
  parameter int unsigned      DEBOUNCE_CYCLES = 50000,
  parameter int unsigned      EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] prev_q;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] edge_s, clr_s;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q, irq_d;
  logic             wr_s;
  logic             unused_wdata;

  assign wr_s         = chipselect & ~write_n;
  assign unused_wdata = ^writedata;

  // Two-flop synchroniser for the asynchronous pins
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
    end else begin
      sync1_q <= in_port;
      sync2_q <= sync1_q;
    end
  end

`ifdef PIO_IN_DEBOUNCE_EN
  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);

  logic [CW-1:0] cnt_q [WIDTH];
  logic [CW-1:0] cnt_d [WIDTH];

  // Per-bit debounce: accept a new level only after it has held for
  // DEBOUNCE_CYCLES consecutive cycles; any return to the stable level
  // restarts the count
  always_comb begin
    stable_d = stable_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] == CW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end
    end
  end

  // Debounce counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end
`else
  assign stable_d = sync2_q;
`endif

  // Debounced state and its one-cycle-delayed copy for edge detection
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable_q <= RESET_LEVEL;
      prev_q   <= RESET_LEVEL;
    end else begin
      stable_q <= stable_d;
      prev_q   <= stable_q;
    end
  end

  if (EDGE_TYPE == 0) begin : g_rise
    assign edge_s = stable_q & ~prev_q;
  end else if (EDGE_TYPE == 1) begin : g_fall
    assign edge_s = ~stable_q & prev_q;
  end else begin : g_any
    assign edge_s = stable_q ^ prev_q;
  end

  // Register-file next state; edge set is OR-ed after the clear so set wins
  always_comb begin
    clr_s  = '0;
    mask_d = mask_q;
    if (wr_s && (address == 2'd3)) begin
      clr_s = writedata[WIDTH-1:0];
    end
    if (wr_s && (address == 2'd2)) begin
      mask_d = writedata[WIDTH-1:0];
    end
    cap_d = (cap_q & ~clr_s) | edge_s;
    irq_d = |(cap_q & mask_q);
    case (address)
      2'd0:    readdata_d = 32'(stable_q);
      2'd2:    readdata_d = 32'(mask_q);
      2'd3:    readdata_d = 32'(cap_q);
      default: readdata_d = '0;
    endcase
  end

  // Mask, capture, interrupt and read-data registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q     <= '0;
      cap_q      <= '0;
      irq_q      <= 1'b0;
      readdata_q <= '0;
    end else begin
      mask_q     <= mask_d;
      cap_q      <= cap_d;
      irq_q      <= irq_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// tb_pio_in_edge_irq: checks three instances (rising, falling, any edge)
// sharing the same pins and bus against a behavioural model.
module tb_pio_in_edge_irq;

  localparam int W = 4;
`ifdef PIO_IN_DEBOUNCE_EN
  localparam int N = 4;
`else
  localparam int N = 1;
`endif

  logic          clk        = 1'b0;
  logic          reset_n    = 1'b0;
  logic [1:0]    address    = 2'd0;
  logic          chipselect = 1'b0;
  logic          write_n    = 1'b1;
  logic [31:0]   writedata  = '0;
  logic [W-1:0]  in_port    = '1;
  logic [31:0]   rd    [3];
  logic          irq_o [3];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  pio_in_edge_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(0)) u_rise (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[0]),
    .in_port(in_port), .irq(irq_o[0]));
  pio_in_edge_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1)) u_fall (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[1]),
    .in_port(in_port), .irq(irq_o[1]));
  pio_in_edge_irq #(.WIDTH(W), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(2)) u_any (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(rd[2]),
    .in_port(in_port), .irq(irq_o[2]));

  // Reference model: pin history window decides the debounced level; a level
  // change becomes a pending edge that lands in capture one cycle later.
  logic [W-1:0] hist[$];
  logic [W-1:0] m_stable, m_mask;
  logic [W-1:0] m_cap  [3];
  logic [W-1:0] m_pend [3];
  logic         m_irq  [3];
  logic [31:0]  m_rd   [3];

  task automatic tick();
    logic [W-1:0] clr, nxt;
    logic         all_diff;
    int           L;
    @(posedge clk);
    if (!reset_n) begin
      hist = {};
      for (int i = 0; i < N + 3; i++) hist.push_back('1);
      m_stable = '1;
      m_mask   = '0;
      for (int k = 0; k < 3; k++) begin
        m_cap[k] = '0; m_pend[k] = '0; m_irq[k] = 1'b0; m_rd[k] = '0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        case (address)
          2'd0:    m_rd[k] = 32'(m_stable);
          2'd2:    m_rd[k] = 32'(m_mask);
          2'd3:    m_rd[k] = 32'(m_cap[k]);
          default: m_rd[k] = '0;
        endcase
        m_irq[k] = |(m_cap[k] & m_mask);
      end
      clr = (chipselect && !write_n && address == 2'd3) ? writedata[W-1:0] : '0;
      for (int k = 0; k < 3; k++) m_cap[k] = (m_cap[k] & ~clr) | m_pend[k];
      if (chipselect && !write_n && address == 2'd2) m_mask = writedata[W-1:0];
      hist.push_back(in_port);
      if (hist.size() > 16) void'(hist.pop_front());
      L   = hist.size();
      nxt = m_stable;
      for (int b = 0; b < W; b++) begin
        all_diff = 1'b1;
        for (int j = 0; j < N; j++) begin
          if (hist[L-3-j][b] == m_stable[b]) all_diff = 1'b0;
        end
        if (all_diff) nxt[b] = ~m_stable[b];
      end
      m_pend[0] = nxt & ~m_stable;
      m_pend[1] = ~nxt & m_stable;
      m_pend[2] = nxt ^ m_stable;
      m_stable  = nxt;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; in_port = '1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (rd[k] !== 32'h0 || irq_o[k] !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_hold inst%0d readdata=%h irq=%b expected 00000000 0", k, rd[k], irq_o[k]);
      end
    end
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      logic [31:0] exp_v;
      address = 2'(a);
      exp_v   = (a == 0) ? 32'h0000000F : 32'h0;
      tick();
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (rd[k] !== exp_v || irq_o[k] !== 1'b0) begin
          tests_failed++;
          $display("FAIL reset_read inst%0d addr%0d readdata=%h irq=%b expected %h 0", k, a, rd[k], irq_o[k], exp_v);
        end
      end
    end
  endtask

  task automatic test_glitch();
    address = 2'd0;
    in_port = 4'hE;
    for (int c = 0; c < 15; c++) begin
      if (c == 3) in_port = 4'hF;
      tick();
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (rd[k] !== m_rd[k] || irq_o[k] !== m_irq[k]) begin
          tests_failed++;
          $display("FAIL glitch inst%0d cyc%0d readdata=%h irq=%b expected %h %b", k, c, rd[k], irq_o[k], m_rd[k], m_irq[k]);
        end
      end
    end
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'hF;
    tick();
    chipselect = 1'b0; write_n = 1'b1; address = 2'd3;
    tick(); tick();
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (rd[k] !== 32'h0 || rd[k] !== m_rd[k]) begin
        tests_failed++;
        $display("FAIL glitch_clear inst%0d capture=%h expected 00000000", k, rd[k]);
      end
    end
  endtask

  task automatic test_latency();
    int seen = -1;
    address = 2'd0;
    in_port = 4'hE;
    for (int c = 1; c <= N + 10; c++) begin
      tick();
      if (seen < 0 && rd[1][3:0] == 4'hE) seen = c;
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (rd[k] !== m_rd[k] || irq_o[k] !== m_irq[k]) begin
          tests_failed++;
          $display("FAIL latency_model inst%0d cyc%0d readdata=%h irq=%b expected %h %b", k, c, rd[k], irq_o[k], m_rd[k], m_irq[k]);
        end
      end
    end
    tests_run++;
    if (seen != N + 3) begin
      tests_failed++;
      $display("FAIL latency data_read_cycle=%0d expected %0d", seen, N + 3);
    end
    address = 2'd3;
    tick();
    tests_run++;
    if (rd[0] !== 32'h0 || rd[1] !== 32'h1 || rd[2] !== 32'h1) begin
      tests_failed++;
      $display("FAIL latency_capture rise=%h fall=%h any=%h expected 0 1 1", rd[0], rd[1], rd[2]);
    end
  endtask

  task automatic test_irq();
    chipselect = 1'b1; write_n = 1'b0; address = 2'd2; writedata = 32'h1;
    tick();
    chipselect = 1'b0; write_n = 1'b1; address = 2'd3;
    tick();
    tests_run++;
    if (irq_o[0] !== 1'b0 || irq_o[1] !== 1'b1 || irq_o[2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_assert irq=%b%b%b expected 011", irq_o[0], irq_o[1], irq_o[2]);
    end
    chipselect = 1'b1; write_n = 1'b0; writedata = 32'h2;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    tick(); tick();
    tests_run++;
    if (irq_o[1] !== 1'b1 || rd[1] !== 32'h1) begin
      tests_failed++;
      $display("FAIL irq_wrong_clear irq=%b capture=%h expected 1 00000001", irq_o[1], rd[1]);
    end
    chipselect = 1'b1; write_n = 1'b0; writedata = 32'h1;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    tests_run++;
    if (irq_o[1] !== 1'b1) begin
      tests_failed++;
      $display("FAIL irq_clear_edge irq=%b expected 1", irq_o[1]);
    end
    tick();
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (irq_o[k] !== 1'b0 || rd[k] !== 32'h0 || irq_o[k] !== m_irq[k]) begin
        tests_failed++;
        $display("FAIL irq_cleared inst%0d irq=%b capture=%h expected 0 00000000", k, irq_o[k], rd[k]);
      end
    end
  endtask

  task automatic test_set_wins();
    in_port = 4'hF;
    repeat (N + 6) tick();
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'hF;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    tick(); tick();
    in_port = 4'hB;
    repeat (N + 2) tick();
    chipselect = 1'b1; write_n = 1'b0; address = 2'd3; writedata = 32'h4;
    tick();
    chipselect = 1'b0; write_n = 1'b1;
    tick();
    tests_run++;
    if (rd[0][2] !== 1'b0 || rd[1][2] !== 1'b1 || rd[2][2] !== 1'b1) begin
      tests_failed++;
      $display("FAIL set_wins bit2 rise=%b fall=%b any=%b expected 0 1 1", rd[0][2], rd[1][2], rd[2][2]);
    end
    for (int k = 0; k < 3; k++) begin
      tests_run++;
      if (rd[k] !== m_rd[k] || irq_o[k] !== m_irq[k]) begin
        tests_failed++;
        $display("FAIL set_wins_model inst%0d readdata=%h irq=%b expected %h %b", k, rd[k], irq_o[k], m_rd[k], m_irq[k]);
      end
    end
  endtask

  task automatic test_reset_mid();
    address = 2'd0;
    in_port = 4'h7;
    tick(); tick(); tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    for (int c = 0; c < N + 8; c++) begin
      tick();
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (rd[k] !== m_rd[k] || irq_o[k] !== m_irq[k]) begin
          tests_failed++;
          $display("FAIL reset_mid inst%0d cyc%0d readdata=%h irq=%b expected %h %b", k, c, rd[k], irq_o[k], m_rd[k], m_irq[k]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 5) == 0) in_port = W'($urandom);
      chipselect = ($urandom_range(0, 3) == 0);
      write_n    = $urandom_range(0, 1) == 1;
      address    = 2'($urandom);
      writedata  = $urandom;
      tick();
      for (int k = 0; k < 3; k++) begin
        tests_run++;
        if (rd[k] !== m_rd[k] || irq_o[k] !== m_irq[k]) begin
          tests_failed++;
          $display("FAIL random inst%0d cyc%0d readdata=%h irq=%b expected %h %b", k, c, rd[k], irq_o[k], m_rd[k], m_irq[k]);
        end
      end
    end
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    #1;
    test_reset();
    test_glitch();
    test_latency();
    test_irq();
    test_set_wins();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/pio_in_edge_irq.md
Name: pio_in_edge_irq

Overview:
Parametrised Avalon-MM slave input port for pushbuttons and switches, successor to the fixed 4-bit read-only PIO. Per bit it provides:
- a 2-FF synchroniser,
- a debounce filter,
- edge detection into a sticky edge-capture register,
- a maskable interrupt.
It sits between the board pins (KEY/SW) and the HPS/Nios interconnect.

Parameters:
WIDTH, 4, number of input bits (1..32).
DEBOUNCE_CYCLES, 50000, clk cycles an input must hold a new level before it is accepted (>=2).
EDGE_TYPE, 1, edge that sets capture: 0 rising, 1 falling, 2 any.
RESET_LEVEL, all ones, reset value of the synchroniser and the debounced state (KEY is active-low, idle high).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
address  in  2  Avalon word address
chipselect  in  1  Avalon select
write_n  in  1  Avalon write strobe, active-low
writedata  in  32  Avalon write data
readdata  out  32  Avalon read data, registered
in_port  in  WIDTH  asynchronous pin inputs
irq  out  1  level interrupt, active-high

Behaviour:
Register map (word address):
- 0 DATA: debounced state, read-only; writes ignored.
- 2 IRQMASK: read/write, WIDTH bits.
- 3 EDGECAPTURE: read; write-1-to-clear per bit.
- 1: reads 0; writes ignored.
- Bits above WIDTH read 0.

Reset (reset_n low, asynchronous):
- sync stages = RESET_LEVEL, stable = RESET_LEVEL, prev = RESET_LEVEL.
- counters = 0, irqmask = 0, edgecapture = 0.
- readdata = 0, irq = 0.
- Reset mid-debounce discards the count.

Synchroniser: in_port passes through 2 flops to give sync[WIDTH-1:0].

Debounce, per bit, independent counter of width clog2(DEBOUNCE_CYCLES):
- sync == stable: counter <= 0.
- sync != stable and counter == DEBOUNCE_CYCLES-1: stable <= sync, counter <= 0.
- otherwise: counter increments.
- A glitch shorter than DEBOUNCE_CYCLES never changes stable. Any return to the stable level restarts the count from 0.
- Latency from pin change to DATA change: 2 sync cycles + DEBOUNCE_CYCLES cycles.

Edge detect:
- prev <= stable every cycle.
- rise = stable & ~prev; fall = ~stable & prev.
- The edge selected by EDGE_TYPE sets edgecapture[i] <= 1 in the following cycle.

EDGECAPTURE write (chipselect & ~write_n & address==3): clears bits where writedata[i]=1. If an edge and a clear hit the same bit in the same cycle, set wins.

IRQMASK write: irqmask <= writedata[WIDTH-1:0].

irq:
- Registered: irq <= |(edgecapture & irqmask), i.e. 1 cycle after the contributing register changes.
- Remains asserted until every masked captured bit is cleared or masked off.

Read:
- readdata <= zero-extended mux(address) every clk; no chipselect qualification.
- Read latency is 1 cycle.
- A read in the same cycle as a write returns the pre-write value.

Optional Feature:
Macro PIO_IN_DEBOUNCE_EN.
- Defined: the debounce filter above is built.
- Undefined: no counters are built and DEBOUNCE_CYCLES is ignored. stable <= sync each cycle, so DATA latency is 3 cycles from the pin (2 sync + 1). Edge detection, capture and irq are otherwise identical.

Test Plan (bench uses WIDTH=4, DEBOUNCE_CYCLES=4, EDGE_TYPE=1, macro defined unless noted):
- Reset then read address 0 -> readdata=32'h0000000F; read addresses 2 and 3 -> 0; irq=0.
- Drive in_port[0] low for 3 cycles then high -> DATA stays 4'hF, EDGECAPTURE stays 0.
- Drive in_port[0] low and hold -> DATA reads 4'hE exactly 2+4 cycles after the pin change; EDGECAPTURE reads 4'h1 one cycle after DATA changes.
- IRQMASK=4'h1 with capture bit 0 set -> irq=1 next cycle; write EDGECAPTURE=4'h1 -> capture=0, irq=0 one cycle later; writing 4'h2 instead leaves irq=1.
- Make a bit-2 edge coincide with a write-1 clear of bit 2 -> EDGECAPTURE bit 2 reads 1.
- Macro undefined, in_port 4'hF->4'h7 -> DATA=4'h7 3 cycles after the pin change. EDGE_TYPE=0: in_port 4'h7->4'hF -> capture bit 3 set. EDGE_TYPE=2: both transitions set capture.
